// File: rtl/fifo_16i_256o_packer.sv
// Width-up gearbox: packs IN_WIDTH lanes into RATIO-lane words, little-endian lane order.
// One accumulator plus one output register; wr_last closes a partial word early.
module fifo_16i_256o_packer #(
    parameter int IN_WIDTH = 16,
    parameter int RATIO = 16,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    output logic                 wr_vld,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 wr_last,
    input  logic                 rd_en,
    output logic                 rd_vld,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic                 rd_last
);
    localparam int IDX_W = $clog2(RATIO);

    logic [RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d, merged, rd_data_q, rd_data_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, rd_cnt_q, rd_cnt_d, lanes;
    logic acc_last_q, acc_last_d, acc_full_q, acc_full_d;
    logic rd_vld_q, rd_vld_d, rd_last_q, rd_last_d, wr_vld_q;
    logic wr_fire, rd_fire, out_free, close;

    assign wr_fire  = wr_en & wr_vld_q;
    assign rd_fire  = rd_en & rd_vld_q;
    assign out_free = ~rd_vld_q | rd_fire;
    assign close    = wr_fire & ((cnt_q == IDX_W'(RATIO - 1)) | wr_last);
    assign lanes    = {1'b0, cnt_q} + CNT_WIDTH'(1);

    // Lanes above cnt_q are already zero because the accumulator clears on every close.
    always_comb begin
        merged        = acc_q;
        merged[cnt_q] = wr_data;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_cnt_d  = acc_cnt_q;
        acc_last_d = acc_last_q;
        acc_full_d = acc_full_q;
        rd_data_d  = rd_data_q;
        rd_cnt_d   = rd_cnt_q;
        rd_last_d  = rd_last_q;
        rd_vld_d   = rd_vld_q & ~rd_fire;
        if (acc_full_q) begin
            // wr_vld is low here, so only a drain can make progress
            if (rd_fire) begin
                rd_data_d  = acc_q;
                rd_cnt_d   = acc_cnt_q;
                rd_last_d  = acc_last_q;
                rd_vld_d   = 1'b1;
                acc_d      = '0;
                acc_cnt_d  = '0;
                acc_last_d = 1'b0;
                acc_full_d = 1'b0;
            end
        end else if (wr_fire) begin
            if (close) begin
                cnt_d = '0;
                if (out_free) begin
                    rd_data_d = merged;
                    rd_cnt_d  = lanes;
                    rd_last_d = wr_last;
                    rd_vld_d  = 1'b1;
                    acc_d     = '0;
                end else begin
                    acc_d      = merged;
                    acc_cnt_d  = lanes;
                    acc_last_d = wr_last;
                    acc_full_d = 1'b1;
                end
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            acc_cnt_q  <= '0;
            acc_last_q <= 1'b0;
            acc_full_q <= 1'b0;
            rd_data_q  <= '0;
            rd_cnt_q   <= '0;
            rd_last_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_last_q <= acc_last_d;
            acc_full_q <= acc_full_d;
            rd_data_q  <= rd_data_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_last_q  <= rd_last_d;
            rd_vld_q   <= rd_vld_d;
            wr_vld_q   <= ~acc_full_d;
        end
    end

    assign wr_vld  = wr_vld_q;
    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;
    assign rd_cnt  = rd_cnt_q;
    assign rd_last = rd_last_q;
endmodule
